aprx_err_monitor: RTL

APRX_ERR_MONITOR -- requirements
Module: aprx_err_monitor

---
 rtl/aprx_pkg.sv | 21 ++
 rtl/aprx_abs_diff.sv | 17 +
 rtl/aprx_err_monitor.sv | 123 ++++++++++++
 3 files changed

// File: rtl/aprx_pkg.sv
// Shared definitions for the approximate-adder error monitor:
// FSM state encoding and error-distance width helpers.
package aprx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 8;

    // The sum of two WIDTH-bit operands needs WIDTH+1 bits, and so does any distance from it.
    localparam int ED_W = DEF_WIDTH + 1;

    function automatic int ed_width(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/aprx_abs_diff.sv
// Combinational absolute difference |x - y|.
// The subtraction is ordered so the result never wraps.
module aprx_abs_diff
    import aprx_pkg::*;
#(
    parameter int W = ED_W
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] d
);

    always_comb begin
        d = (x >= y) ? (x - y) : (y - x);
    end

endmodule

// File: rtl/aprx_err_monitor.sv
// Error-statistics monitor for an approximate adder. Samples pass through a
// two-stage pipeline (distance, then accumulate) under a small run-control FSM.
module aprx_err_monitor
    import aprx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [WIDTH:0]           in_approx,
    input  logic                     in_last,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         sample_cnt,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [CNT_W+WIDTH:0]     sum_ed,
    output logic [WIDTH:0]           max_ed
);

    localparam int EW = ed_width(WIDTH);
    localparam int SW = CNT_W + WIDTH + 1;

    state_t          state;
    state_t          next_state;
    logic            drain_cnt;
    logic            accept;
    logic            start_ok;
    logic [EW-1:0]   exact;
    logic [EW-1:0]   ed_comb;
    logic            s1_valid;
    logic [EW-1:0]   s1_ed;
    logic [SW:0]     sum_wide;

    assign accept   = in_valid && in_ready;
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign exact    = EW'(in_a) + EW'(in_b);

    aprx_abs_diff #(
        .W (EW)
    ) u_abs_diff (
        .x (exact),
        .y (in_approx),
        .d (ed_comb)
    );

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_RUN;
            end
            ST_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && in_last) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt) next_state = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) next_state = ST_RUN;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // DRAIN lasts two cycles, long enough for the final sample to clear both stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            drain_cnt <= 1'b0;
        end else begin
            state     <= next_state;
            drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_ed    <= '0;
        end else if (start_ok) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) s1_ed <= ed_comb;
        end
    end

    assign sum_wide = {1'b0, sum_ed} + (SW + 1)'(s1_ed);

    // All accumulators saturate rather than wrap, so an overflowed run still reads as "huge".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
        end else if (start_ok) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            sum_ed     <= '0;
            max_ed     <= '0;
        end else if (s1_valid) begin
            if (sample_cnt != '1) sample_cnt <= sample_cnt + 1'b1;
            if ((s1_ed != '0) && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
            sum_ed <= sum_wide[SW] ? '1 : sum_wide[SW-1:0];
            if (s1_ed > max_ed) max_ed <= s1_ed;
        end
    end

endmodule
